trigger_phase_capture: RTL and testbench

Receive-side counterpart of the per-channel phase-adjusted trigger generator. It arms on BSYNC and measures, in clk cycles, the phase offset of an incoming trigger pulse relative to the BSYNC reference edge, and the width of that pulse. It checks the width against the expected BSYNC ratio and returns one result per pulse over a valid/ready handshake. It sits beside the trigger channels in the axi_adf4030 block for loopback calibration and for monitoring trigger alignment.

---
 rtl/trigger_pkg.sv | 15 +
 rtl/trigger_phase_capture_if.sv | 23 ++
 rtl/trigger_edge_detect.sv | 42 ++++
 rtl/trigger_phase_capture.sv | 163 ++++++++++++++++
 tb/tb_trigger_phase_capture.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/trigger_pkg.sv
// Shared types and constants for the trigger phase capture block.
package trigger_pkg;

  localparam int STATE_WIDTH   = 3;
  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    PHASE  = 3'd2,
    WIDTH  = 3'd3,
    REPORT = 3'd4
  } cap_state_t;

endpackage

// File: rtl/trigger_phase_capture_if.sv
// Result handshake bundle: one phase/width measurement per valid/ready transfer.
interface trigger_phase_capture_if #(
  parameter int CNT_W = 16
);

  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] meas_phase;
  logic [CNT_W-1:0] meas_width;
  logic             width_err;
  logic             timeout_err;

  modport master (
    output meas_valid, meas_phase, meas_width, width_err, timeout_err,
    input  meas_ready
  );

  modport slave (
    input  meas_valid, meas_phase, meas_width, width_err, timeout_err,
    output meas_ready
  );

endinterface

// File: rtl/trigger_edge_detect.sv
// Sample register and rising-edge pulse for one input; TRIGGER_CAPTURE_CDC_EN adds a
// 2-flop synchronizer ahead of the sample register.
module trigger_edge_detect (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic level,
  output logic rise
);

  logic sample_src;
  logic sample_p1;
  logic prev_p2;

`ifdef TRIGGER_CAPTURE_CDC_EN
  logic [1:0] sync_p0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_p0 <= 2'b00;
    else       sync_p0 <= {sync_p0[0], din};
  end

  assign sample_src = sync_p0[1];
`else
  assign sample_src = din;
`endif

  // sample / previous-sample stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sample_p1 <= 1'b0;
      prev_p2   <= 1'b0;
    end else begin
      sample_p1 <= sample_src;
      prev_p2   <= sample_p1;
    end
  end

  assign level = sample_p1;
  assign rise  = sample_p1 & ~prev_p2;

endmodule

// File: rtl/trigger_phase_capture.sv
// Measures trigger phase relative to the BSYNC rising edge and trigger pulse width.
// Optional macro TRIGGER_CAPTURE_CDC_EN enables input synchronizers in the edge detectors.
module trigger_phase_capture
  import trigger_pkg::*;
#(
  parameter int CNT_W     = DEFAULT_CNT_W,
  parameter int WIDTH_TOL = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    ch_en,
  input  logic                    bsync_ready,
  input  logic                    bsync,
  input  logic                    trig_in,
  input  logic [CNT_W-1:0]        bsync_ratio,
  input  logic [CNT_W-1:0]        timeout,
  trigger_phase_capture_if.master meas,
  output logic [STATE_WIDTH-1:0]  cap_state
);

  cap_state_t       state, state_n;
  logic [CNT_W-1:0] phase_cnt, phase_cnt_n, width_cnt, width_cnt_n;
  logic [CNT_W-1:0] phase_q, phase_n, width_q, width_n;
  logic             werr_q, werr_n, terr_q, terr_n;
  logic [CNT_W-1:0] phase_inc, width_inc;
  logic             bsync_lvl, bsync_rise, trig_lvl, trig_rise;
  logic             en_ok, ref_edge;

  function automatic logic hit_limit(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] tmo);
    return ((tmo != '0) && (cnt >= tmo)) || (cnt == '1);
  endfunction

  // Absolute difference kept one bit wider so it cannot wrap.
  function automatic logic width_off(input logic [CNT_W-1:0] meas_w,
                                     input logic [CNT_W-1:0] exp_w);
    logic [CNT_W:0] diff;
    if (meas_w >= exp_w) diff = {1'b0, meas_w} - {1'b0, exp_w};
    else                 diff = {1'b0, exp_w} - {1'b0, meas_w};
    return diff > (CNT_W+1)'(WIDTH_TOL);
  endfunction

  trigger_edge_detect u_bsync_edge (
    .clk   (clk),
    .rstn  (rstn),
    .din   (bsync),
    .level (bsync_lvl),
    .rise  (bsync_rise)
  );

  trigger_edge_detect u_trig_edge (
    .clk   (clk),
    .rstn  (rstn),
    .din   (trig_in),
    .level (trig_lvl),
    .rise  (trig_rise)
  );

  assign en_ok     = ch_en & bsync_ready;
  assign ref_edge  = bsync_rise & bsync_lvl;
  assign phase_inc = phase_cnt + CNT_W'(1);
  assign width_inc = width_cnt + CNT_W'(1);

  always_comb begin
    state_n     = state;
    phase_cnt_n = phase_cnt;
    width_cnt_n = width_cnt;
    phase_n     = phase_q;
    width_n     = width_q;
    werr_n      = werr_q;
    terr_n      = terr_q;
    case (state)
      IDLE: if (en_ok) state_n = ARM;
      ARM: begin
        if (!en_ok) begin
          state_n = IDLE;
        end else if (ref_edge) begin
          // Coincident trigger edge means zero phase and skips PHASE entirely.
          if (trig_rise) begin
            phase_n     = '0;
            width_cnt_n = CNT_W'(1);
            state_n     = WIDTH;
          end else begin
            phase_cnt_n = '0;
            state_n     = PHASE;
          end
        end
      end
      PHASE: begin
        if (!en_ok) begin
          state_n = IDLE;
        end else if (hit_limit(phase_inc, timeout)) begin
          phase_n = phase_inc;
          width_n = '0;
          werr_n  = 1'b0;
          terr_n  = 1'b1;
          state_n = REPORT;
        end else if (trig_rise) begin
          phase_n     = phase_inc;
          width_cnt_n = CNT_W'(1);
          state_n     = WIDTH;
        end else begin
          phase_cnt_n = phase_inc;
        end
      end
      WIDTH: begin
        if (!en_ok) begin
          state_n = IDLE;
        end else if (trig_lvl) begin
          if (hit_limit(width_inc, timeout)) begin
            width_n = width_inc;
            werr_n  = 1'b0;
            terr_n  = 1'b1;
            state_n = REPORT;
          end else begin
            width_cnt_n = width_inc;
          end
        end else begin
          width_n = width_cnt;
          werr_n  = width_off(width_cnt, bsync_ratio);
          terr_n  = 1'b0;
          state_n = REPORT;
        end
      end
      REPORT: begin
        if (meas.meas_ready) begin
          werr_n  = 1'b0;
          terr_n  = 1'b0;
          state_n = en_ok ? ARM : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      phase_cnt <= '0;
      width_cnt <= '0;
      phase_q   <= '0;
      width_q   <= '0;
      werr_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state     <= state_n;
      phase_cnt <= phase_cnt_n;
      width_cnt <= width_cnt_n;
      phase_q   <= phase_n;
      width_q   <= width_n;
      werr_q    <= werr_n;
      terr_q    <= terr_n;
    end
  end

  assign meas.meas_valid  = (state == REPORT);
  assign meas.meas_phase  = phase_q;
  assign meas.meas_width  = width_q;
  assign meas.width_err   = werr_q;
  assign meas.timeout_err = terr_q;
  assign cap_state        = state;

endmodule

// File: tb/tb_trigger_phase_capture.sv
// Bench for trigger_phase_capture: directed edge cases plus random pulse trains against a
// reference model that derives results from edge times on the recorded stimulus.
module tb_trigger_phase_capture;
  import trigger_pkg::*;

  localparam int CNT_W = 16;
  localparam int N     = 400;

  logic             clk = 1'b0;
  logic             rstn, ch_en, bsync_ready, bsync, trig_in;
  logic [CNT_W-1:0] bsync_ratio, timeout;
  logic [2:0]       cap_state;

  trigger_phase_capture_if #(.CNT_W(CNT_W)) mif ();

  trigger_phase_capture #(.CNT_W(CNT_W), .WIDTH_TOL(1)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .ch_en       (ch_en),
    .bsync_ready (bsync_ready),
    .bsync       (bsync),
    .trig_in     (trig_in),
    .bsync_ratio (bsync_ratio),
    .timeout     (timeout),
    .meas        (mif.master),
    .cap_state   (cap_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int phase;
    int width;
    bit werr;
    bit terr;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  bit   bs_a[N], tr_a[N], rd_a[N];
  int   ratio_v, tmo_v, valid_cycles;
  res_t exp_q[$], got_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit bs_rise(input int k);
    return (k >= 1) && (k < N) && bs_a[k] && !bs_a[k-1];
  endfunction

  function automatic bit tr_rise(input int k);
    return (k >= 1) && (k < N) && tr_a[k] && !tr_a[k-1];
  endfunction

  // Walks the stimulus as a sequence of measurements: reference edge, trigger edge,
  // pulse run length, then the first accepting ready; the next search starts there.
  task automatic model(input int n);
    int arm_at, r, k, j, len, e_rep, e_hs;
    res_t res;
    exp_q.delete();
    arm_at = 0;
    forever begin
      r = -1;
      for (int t = (arm_at < 1 ? 1 : arm_at); t < n; t++)
        if (bs_rise(t)) begin r = t; break; end
      if (r < 0) break;
      k = -1;
      for (int t = r; t < n; t++)
        if (tr_rise(t)) begin k = t; break; end
      j = (k < 0) ? 1000000 : k - r;
      if (k != r && tmo_v != 0 && j >= tmo_v) begin
        res = '{tmo_v, 0, 1'b0, 1'b1};
        e_rep = r + 1 + tmo_v;
      end else if (k < 0) begin
        break;
      end else begin
        len = 0;
        while (k + len < n && tr_a[k+len]) len++;
        if (tmo_v != 0 && len >= tmo_v) begin
          res = '{j, tmo_v, 1'b0, 1'b1};
          e_rep = k + tmo_v;
        end else if (k + len >= n) begin
          break;
        end else begin
          res = '{j, len, ((len > ratio_v) ? len - ratio_v : ratio_v - len) > 1, 1'b0};
          e_rep = k + 1 + len;
        end
      end
      e_hs = -1;
      for (int t = e_rep + 1; t < n; t++)
        if (rd_a[t]) begin e_hs = t; break; end
      if (e_hs < 0) break;
      exp_q.push_back(res);
      arm_at = e_hs;
    end
  endtask

  task automatic clear_arrays();
    for (int i = 0; i < N; i++) begin
      bs_a[i] = 1'b0;
      tr_a[i] = 1'b0;
      rd_a[i] = 1'b1;
    end
  endtask

  task automatic run_scn(input string tag, input int n);
    rstn = 1'b0; ch_en = 1'b0; bsync_ready = 1'b0; bsync = 1'b0; trig_in = 1'b0;
    mif.meas_ready = 1'b0;
    bsync_ratio = CNT_W'(ratio_v);
    timeout     = CNT_W'(tmo_v);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    got_q.delete();
    valid_cycles = 0;
    for (int k = 0; k < n; k++) begin
      ch_en = 1'b1; bsync_ready = 1'b1;
      bsync = bs_a[k]; trig_in = tr_a[k]; mif.meas_ready = rd_a[k];
      if (mif.meas_valid) valid_cycles++;
      if (mif.meas_valid && rd_a[k])
        got_q.push_back('{int'(mif.meas_phase), int'(mif.meas_width),
                          mif.width_err, mif.timeout_err});
      @(negedge clk);
    end
    model(n);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_phase%0d", tag, i), got_q[i].phase, exp_q[i].phase);
      chk($sformatf("%s_width%0d", tag, i), got_q[i].width, exp_q[i].width);
      chk($sformatf("%s_werr%0d", tag, i), got_q[i].werr, exp_q[i].werr);
      chk($sformatf("%s_terr%0d", tag, i), got_q[i].terr, exp_q[i].terr);
    end
  endtask

  task automatic basic_pulse(input int ratio);
    clear_arrays();
    for (int i = 10; i < 30; i++) bs_a[i] = 1'b1;
    for (int i = 35; i <= 42; i++) tr_a[i] = 1'b1;
    ratio_v = ratio; tmo_v = 0;
  endtask

  initial begin
    int vcount, per, st, w;
    rstn = 1'b0; ch_en = 1'b0; bsync_ready = 1'b0; bsync = 1'b0; trig_in = 1'b0;
    bsync_ratio = '0; timeout = '0; mif.meas_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", mif.meas_valid, 0);
    chk("rst_phase", mif.meas_phase, 0);
    chk("rst_width", mif.meas_width, 0);
    chk("rst_werr", mif.width_err, 0);
    chk("rst_terr", mif.timeout_err, 0);
    chk("rst_state", cap_state, IDLE);

    // Enable drop mid-WIDTH, then asynchronous reset mid-PHASE.
    rstn = 1'b1; ch_en = 1'b1; bsync_ready = 1'b1; mif.meas_ready = 1'b1;
    bsync_ratio = CNT_W'(8); timeout = '0;
    for (int i = 0; i < 14; i++) begin
      bsync = (i >= 5); trig_in = (i >= 10);
      @(negedge clk);
    end
    chk("mid_width_state", cap_state, WIDTH);
    ch_en = 1'b0;
    @(negedge clk);
    chk("en_drop_state", cap_state, IDLE);
    chk("en_drop_valid", mif.meas_valid, 0);
    vcount = 0;
    ch_en = 1'b1;
    for (int i = 15; i < 23; i++) begin
      bsync = (i >= 18); trig_in = 1'b1;
      if (mif.meas_valid) vcount++;
      @(negedge clk);
    end
    chk("en_drop_no_result", vcount, 0);
    chk("rearm_phase_state", cap_state, PHASE);
    chk("held_phase", mif.meas_phase, 5);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_state", cap_state, IDLE);
    chk("async_rst_phase", mif.meas_phase, 0);
    chk("async_rst_valid", mif.meas_valid, 0);
    chk("async_rst_width", mif.meas_width, 0);

    basic_pulse(8);
    run_scn("tp_basic", 80);
    chk("tp_basic_valid_cycles", valid_cycles, 1);
    if (got_q.size() > 0) begin
      chk("tp_basic_phase_abs", got_q[0].phase, 25);
      chk("tp_basic_width_abs", got_q[0].width, 8);
      chk("tp_basic_werr_abs", got_q[0].werr, 0);
    end
    basic_pulse(5);
    run_scn("tp_ratio5", 80);
    if (got_q.size() > 0) chk("tp_ratio5_werr_abs", got_q[0].werr, 1);
    basic_pulse(7);
    run_scn("tp_ratio7", 80);
    if (got_q.size() > 0) chk("tp_ratio7_werr_abs", got_q[0].werr, 0);

    clear_arrays();
    for (int i = 10; i < 30; i++) bs_a[i] = 1'b1;
    ratio_v = 8; tmo_v = 20;
    run_scn("tp_timeout", 80);
    if (got_q.size() > 0) begin
      chk("tp_timeout_phase_abs", got_q[0].phase, 20);
      chk("tp_timeout_terr_abs", got_q[0].terr, 1);
    end

    clear_arrays();
    for (int i = 10; i < 30; i++) bs_a[i] = 1'b1;
    for (int i = 10; i < 16; i++) tr_a[i] = 1'b1;
    ratio_v = 6; tmo_v = 0;
    run_scn("tp_same_edge", 60);
    if (got_q.size() > 0) chk("tp_same_edge_phase_abs", got_q[0].phase, 0);

    clear_arrays();
    for (int i = 10; i < 30; i++) bs_a[i] = 1'b1;
    for (int i = 50; i < 56; i++) bs_a[i] = 1'b1;
    for (int i = 110; i < 131; i++) bs_a[i] = 1'b1;
    for (int i = 35; i <= 42; i++) tr_a[i] = 1'b1;
    for (int i = 60; i <= 63; i++) tr_a[i] = 1'b1;
    for (int i = 120; i <= 124; i++) tr_a[i] = 1'b1;
    for (int i = 0; i < 95; i++) rd_a[i] = 1'b0;
    ratio_v = 8; tmo_v = 0;
    run_scn("tp_backpressure", 160);
    if (got_q.size() > 1) begin
      chk("tp_bp_first_phase_abs", got_q[0].phase, 25);
      chk("tp_bp_second_phase_abs", got_q[1].phase, 10);
      chk("tp_bp_second_width_abs", got_q[1].width, 5);
    end

    for (int s = 0; s < 8; s++) begin
      clear_arrays();
      per = 30 + int'($urandom_range(0, 30));
      for (int b = 10; b < 300; b += per) begin
        for (int i = b; i < b + per / 2 && i < N; i++) bs_a[i] = 1'b1;
        if ($urandom_range(0, 3) != 0) begin
          st = b + int'($urandom_range(0, per - 1));
          w  = 1 + int'($urandom_range(0, 11));
          for (int i = st; i < st + w && i < N; i++) tr_a[i] = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) rd_a[i] = ($urandom_range(0, 9) < 7);
      ratio_v = 3 + int'($urandom_range(0, 7));
      tmo_v   = ($urandom_range(0, 2) == 0) ? 5 + int'($urandom_range(0, 35)) : 0;
      run_scn($sformatf("rnd%0d", s), 300);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
